layer4_act_loader: RTL and testbench

//  Serial-to-parallel activation buffer that feeds the layer-4 node array.
//  - Accepts one IEEE-754 single-precision activation per beat on a valid/ready stream.
//  - Assembles N_IN words into a frame and holds the vector stable for the purely

---
 rtl/layer4_act_loader.sv | 113 +++++++++++
 tb/tb_layer4_act_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer4_act_loader.sv
// Serial-to-parallel activation loader for the layer-4 node array: collects N_IN
// words per frame, holds them stable, and flags act_valid once the trees settle.

module layer4_act_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module layer4_act_loader #(
  parameter int N_IN          = 15,
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_last,
  output logic [N_IN*WIDTH-1:0] act_flat,
  output logic                  act_valid,
  input  logic                  act_ack,
  output logic                  err_len
);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);
  localparam logic [7:0]    CNT_END  = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {FILL, DRAIN, SETTLE, HOLD} state_t;

  state_t                      state;
  logic [IW-1:0]               idx;
  logic [7:0]                  cnt;
  logic [N_IN-1:0][WIDTH-1:0]  slot_q;
  logic                        xfer;

  assign xfer     = in_valid & in_ready;
  assign act_flat = slot_q;

  // Slots only load in FILL, so the vector is frozen through SETTLE and HOLD.
  for (genvar k = 0; k < N_IN; k++) begin : g_slot
    layer4_act_slot #(.WIDTH(WIDTH)) u_slot (
      .clk (clk),
      .rst (rst),
      .we  ((state == FILL) && xfer && (idx == IW'(k))),
      .d   (in_data),
      .q   (slot_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      cnt       <= '0;
      act_valid <= 1'b0;
      err_len   <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      err_len <= 1'b0;
      case (state)
        FILL: if (xfer) begin
          if (idx == LAST_IDX) begin
            idx <= '0;
            if (in_last) begin
              state    <= SETTLE;
              cnt      <= '0;
              in_ready <= 1'b0;
            end else begin
              err_len <= 1'b1;
              state   <= DRAIN;
            end
          end else if (in_last) begin
            err_len <= 1'b1;
            idx     <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        // Tail of an over-long frame: swallow words up to its in_last.
        DRAIN: if (xfer && in_last) begin
          state <= FILL;
          idx   <= '0;
        end
        SETTLE: begin
          if (cnt == CNT_END) begin
            state     <= HOLD;
            act_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: if (act_ack) begin
          state     <= FILL;
          act_valid <= 1'b0;
          in_ready  <= 1'b1;
          idx       <= '0;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_layer4_act_loader.sv
// Scoreboard bench for layer4_act_loader: drivers push expected frames / error
// pulses with their due cycle, a negedge monitor pops and compares.

module tb_layer4_act_loader;
  localparam int N  = 15;
  localparam int W  = 32;
  localparam int SC = 4;
  localparam int FW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic [FW-1:0] act_flat;
  logic          act_valid;
  logic          act_ack = 1'b0;
  logic          err_len;

  layer4_act_loader #(.N_IN(N), .WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .act_flat(act_flat),
    .act_valid(act_valid), .act_ack(act_ack), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [FW-1:0] flat;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   rise_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   ack_e = 1'b0;
  bit   rst_e = 1'b1;
  bit   prev_av = 1'b0;
  bit   prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    ack_e = act_ack;
    rst_e = rst;
  end

  task automatic chk(input bit ok, input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  // Monitor: scoreboard pops on act_valid rise and err_len, plus hold/ack behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_e) begin
      if (act_valid && !prev_av) begin
        rise_q.push_back(cyc);
        chk(sb.size() > 0 && !sb[0].is_err, "act_valid_expected", FW'(act_valid), FW'(0));
        if (sb.size() > 0 && !sb[0].is_err) begin
          e = sb.pop_front();
          chk(act_flat == e.flat, "act_flat", act_flat, e.flat);
          chk(cyc == e.cyc, "act_valid_latency", FW'(cyc), FW'(e.cyc));
        end
      end
      if (err_len) begin
        chk(sb.size() > 0 && sb[0].is_err, "err_len_expected", FW'(err_len), FW'(0));
        chk(!prev_err, "err_len_single_cycle", FW'(prev_err), FW'(0));
        if (sb.size() > 0 && sb[0].is_err) begin
          e = sb.pop_front();
          chk(cyc == e.cyc, "err_len_timing", FW'(cyc), FW'(e.cyc));
        end
      end
      if (prev_av) begin
        if (ack_e) chk(!act_valid && in_ready, "ack_release", {act_valid, in_ready}, 2'b01);
        else       chk(act_valid && !in_ready, "hold_stable", {act_valid, in_ready}, 2'b10);
      end
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        n_chk++;
        $display("FAIL missed_event: is_err=%0d due cycle %0d, now %0d", sb[0].is_err, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
    end
    prev_av  = act_valid;
    prev_err = err_len;
  end

  task automatic send_word(input logic [W-1:0] d, input bit l, input bit gaps, output int acc);
    int  tries = 0;
    bit  done  = 1'b0;
    bit  rdy;
    acc = 0;
    while (!done) begin
      @(negedge clk);
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = d;
      in_last  = l;
      rdy      = in_ready;
      @(posedge clk);
      if (in_valid && rdy) begin
        done = 1'b1;
        acc  = cyc + 1;
      end else if (++tries > 200) begin
        n_chk++;
        $display("FAIL accept_timeout: in_ready=%0d after %0d cycles, required 1", in_ready, tries);
        summary();
      end
    end
  endtask

  // Good frame: n==N, last on word N-1. Short: last before N-1. Long: n>N.
  task automatic send_frame(input int n, input int last_at, input logic [W-1:0] base, input bit gaps);
    logic [FW-1:0] f = '0;
    int acc;
    for (int k = 0; k < n; k++) begin
      send_word(base + W'(k), k == last_at, gaps, acc);
      if (k < N) f[k*W +: W] = base + W'(k);
      if (n == N && last_at == N-1 && k == N-1) sb.push_back('{1'b0, f, acc + SC});
      else if (last_at < N-1 && k == last_at)   sb.push_back('{1'b1, '0, acc});
      else if (n > N && k == N-1)               sb.push_back('{1'b1, '0, acc});
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!act_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!act_valid) begin
      n_chk++;
      $display("FAIL act_valid_timeout: act_valid=%0d, required 1", act_valid);
    end
  endtask

  task automatic ack_pulse();
    act_ack = 1'b1;
    @(negedge clk);
    act_ack = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk(act_valid == 1'b0, {tag, "_act_valid"}, FW'(act_valid), FW'(0));
    chk(act_flat == '0,    {tag, "_act_flat"},  act_flat, '0);
    chk(in_ready == 1'b1,  {tag, "_in_ready"},  FW'(in_ready), FW'(1));
    chk(err_len == 1'b0,   {tag, "_err_len"},   FW'(err_len), FW'(0));
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // 1: plain good frame, held three cycles before ack
    send_frame(15, 14, 32'h3F80_0000, 1'b0);
    wait_valid();
    repeat (3) @(negedge clk);
    ack_pulse();

    // 2: short frame, then a good frame with negative denormals
    send_frame(7, 6, 32'h4000_0000, 1'b0);
    repeat (3) @(negedge clk);
    send_frame(15, 14, 32'h8000_0001, 1'b0);
    wait_valid();
    ack_pulse();

    // 3: 20-word frame (dropped), then a NaN-payload frame
    send_frame(20, 19, 32'h1234_0000, 1'b0);
    send_frame(15, 14, 32'h7FC0_0000, 1'b0);
    wait_valid();
    ack_pulse();

    // 4: random valid gaps, same data as scenario 1
    send_frame(15, 14, 32'h3F80_0000, 1'b1);
    wait_valid();
    ack_pulse();

    // 5a: reset while in HOLD
    send_frame(15, 14, 32'hC0A0_0000, 1'b0);
    wait_valid();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_hold");
    send_frame(15, 14, 32'h3E00_0000, 1'b0);
    wait_valid();
    ack_pulse();

    // 5b: reset while in SETTLE (frame never completes)
    send_frame(15, 14, 32'h4100_0000, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_settle");
    send_frame(15, 14, 32'h3C00_0000, 1'b0);
    wait_valid();
    ack_pulse();

    // 6: ack tied high over three back-to-back frames
    rise_q.delete();
    act_ack = 1'b1;
    send_frame(15, 14, 32'h0000_0100, 1'b0);
    send_frame(15, 14, 32'h0000_0200, 1'b0);
    send_frame(15, 14, 32'h0000_0300, 1'b0);
    repeat (8) @(negedge clk);
    act_ack = 1'b0;
    chk(rise_q.size() == 3, "b2b_frame_count", FW'(rise_q.size()), FW'(3));
    for (int i = 1; i < rise_q.size(); i++)
      chk(rise_q[i] - rise_q[i-1] == 20, "b2b_spacing", FW'(rise_q[i] - rise_q[i-1]), FW'(20));

    t = 0;
    while (sb.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    summary();
  end
endmodule
